lane_hit_judge: RTL

//  Per-lane judge for the rhythm game: the consuming end of a scrolling note lane.
//  It watches the lane's occupancy as notes scroll from row 15 toward row 0, and

---
 rtl/lane_hit_judge.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lane_hit_judge.sv
// Per-lane judge: debounces the lane key, grades the lowest notes on a press,
// flags notes that scroll out unjudged, and keeps score/combo counters.
module lane_hit_judge #(
    parameter int DEBOUNCE = 1000,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          key_n,
    input  logic          game_en,
    input  logic [15:0]   lane_rows,
    input  logic          shift_tick,
    output logic          score,
    output logic          near,
    output logic          miss,
    output logic [7:0]    clr_slot,
    output logic [CW-1:0] hits,
    output logic [CW-1:0] nears,
    output logic [CW-1:0] misses,
    output logic [CW-1:0] combo,
    output logic [CW-1:0] max_combo
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic {
        KEY_RELEASED = 1'b0,
        KEY_HELD     = 1'b1
    } key_state_t;

    // ---------------------------------------------------------------
    // Key synchroniser and debounce
    // ---------------------------------------------------------------
    // The synchroniser stores the inverted key so a cleared register means "released".
    logic          sync1_reg;
    logic          sync2_reg;
    logic          key_s;
    logic          key_stable_reg;
    logic [DW-1:0] db_cnt_reg;

    assign key_s = sync2_reg;

    always_ff @(posedge clk) begin
        if (RST) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= ~key_n;
            sync2_reg <= sync1_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            key_stable_reg <= 1'b0;
            db_cnt_reg     <= '0;
        end else if (key_s != key_stable_reg) begin
            if (db_cnt_reg == DW'(DEBOUNCE - 1)) begin
                key_stable_reg <= key_s;
                db_cnt_reg     <= '0;
            end else begin
                db_cnt_reg <= db_cnt_reg + DW'(1);
            end
        end else begin
            db_cnt_reg <= '0;
        end
    end

    // ---------------------------------------------------------------
    // Key FSM: a single press event on the rising edge of the debounced level
    // ---------------------------------------------------------------
    key_state_t key_state_reg;
    key_state_t key_state_next;
    logic       press_raw;

    always_ff @(posedge clk) begin
        if (RST) begin
            key_state_reg <= KEY_RELEASED;
        end else begin
            key_state_reg <= key_state_next;
        end
    end

    always_comb begin
        key_state_next = key_state_reg;
        press_raw      = 1'b0;
        case (key_state_reg)
            KEY_RELEASED: begin
                if (key_stable_reg) begin
                    key_state_next = KEY_HELD;
                    press_raw      = 1'b1;
                end
            end
            KEY_HELD: begin
                if (!key_stable_reg) begin
                    key_state_next = KEY_RELEASED;
                end
            end
            default: key_state_next = KEY_RELEASED;
        endcase
    end

    // ---------------------------------------------------------------
    // Slot occupancy and grading
    // ---------------------------------------------------------------
    logic [7:0] occ;
    logic [7:0] judged_reg;
    logic [7:0] judged_next;
    logic [7:0] set_mask;
    logic       press_ev;
    logic       hit0;
    logic       hit1;
    logic       miss_ev;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_occ
            assign occ[gi] = |lane_rows[2*gi+1 -: 2];
        end
    endgenerate

    assign press_ev = press_raw & game_en;
    assign hit0     = press_ev & occ[0] & ~judged_reg[0];
    assign hit1     = press_ev & ~hit0 & occ[1] & ~judged_reg[1];
    assign set_mask = {6'b0, hit1, hit0};
    // A note graded in this very cycle is never also counted as scrolling out.
    assign miss_ev  = shift_tick & game_en & occ[0] & ~(judged_reg[0] | set_mask[0]);

    always_comb begin
        judged_next = judged_reg | set_mask;
        if (!game_en) begin
            judged_next = '0;
        end else if (shift_tick) begin
            judged_next = {1'b0, judged_next[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            judged_reg <= '0;
        end else begin
            judged_reg <= judged_next;
        end
    end

    // ---------------------------------------------------------------
    // Registered pulses and saturating counters
    // ---------------------------------------------------------------
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    logic [CW-1:0] combo_next;
    logic [CW-1:0] max_combo_next;

    always_comb begin
        combo_next = combo;
        if (miss_ev) begin
            combo_next = '0;
        end else if (hit0 | hit1) begin
            combo_next = sat_inc(combo);
        end
        max_combo_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            score     <= 1'b0;
            near      <= 1'b0;
            miss      <= 1'b0;
            clr_slot  <= '0;
            hits      <= '0;
            nears     <= '0;
            misses    <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            score     <= hit0;
            near      <= hit1;
            miss      <= miss_ev;
            clr_slot  <= set_mask;
            combo     <= combo_next;
            max_combo <= max_combo_next;
            if (hit0) begin
                hits <= sat_inc(hits);
            end
            if (hit1) begin
                nears <= sat_inc(nears);
            end
            if (miss_ev) begin
                misses <= sat_inc(misses);
            end
        end
    end

endmodule
